seq2_ctrl: RTL



---
 rtl/seq2_pkg.sv | 33 +++
 rtl/seq2_progmem.sv | 36 +++
 rtl/seq2_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/seq2_pkg.sv
// rtl/seq2_pkg.sv - shared encodings for the Seq2 run-control block
package seq2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BOOT   = 3'd1,
        ST_FETCH  = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_PAUSED = 3'd4,
        ST_ERROR  = 3'd5
    } ctrl_state_e;

    typedef enum logic [1:0] {
        CMD_STOP  = 2'd0,
        CMD_RUN   = 2'd1,
        CMD_STEP  = 2'd2,
        CMD_PAUSE = 2'd3
    } cmd_e;

    localparam logic [3:0] OP_NO = 4'd0;
    localparam logic [3:0] OP_CI = 4'd1;
    localparam logic [3:0] OP_CR = 4'd2;
    localparam logic [3:0] OP_JI = 4'd3;
    localparam logic [3:0] OP_JR = 4'd4;
    localparam logic [3:0] OP_JZ = 4'd5;

    localparam logic [3:0] SEQ2_OP_MAX = OP_JZ;

    function automatic logic op_illegal(input logic [3:0] op);
        return op > SEQ2_OP_MAX;
    endfunction

endpackage

// File: rtl/seq2_progmem.sv
// rtl/seq2_progmem.sv - single-port program RAM with registered read
module seq2_progmem #(
    parameter int AW = 8,
    parameter int IW = 20
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [IW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [IW-1:0] rd_data
);

    logic [IW-1:0] mem_q [0:(1<<AW)-1];
    logic [IW-1:0] rd_data_q;

    // Array contents survive reset; only the read register is cleared.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/seq2_ctrl.sv
// rtl/seq2_ctrl.sv - run-control FSM feeding Seq2 from program memory
module seq2_ctrl
    import seq2_pkg::*;
#(
    parameter int AW   = 8,
    parameter int IW   = 20,
    parameter int CNTW = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            prog_wen,
    input  logic [AW-1:0]   prog_addr,
    input  logic [IW-1:0]   prog_data,
    input  logic            cmd_en,
    input  logic [1:0]      cmd,
    input  logic            bp_en,
    input  logic [AW-1:0]   bp_addr,
    input  logic [AW-1:0]   seq_next,
    output logic [IW-1:0]   seq_inst,
    output logic            seq_inst_en,
    output logic            seq_reset,
    output logic [2:0]      state,
    output logic [CNTW-1:0] icount,
    output logic            trap
);

    ctrl_state_e     state_q, state_d;
    logic            step_q, step_d;
    logic            chk_q, chk_d;
    logic            pend_q, pend_d;
    logic [CNTW-1:0] icount_q, icount_d;
    logic            trap_q, trap_d;
    logic            rd_en;
    logic            mem_wen;

    logic c_stop, c_run, c_step, c_pause;
    assign c_stop  = cmd_en && (cmd == CMD_STOP);
    assign c_run   = cmd_en && (cmd == CMD_RUN);
    assign c_step  = cmd_en && (cmd == CMD_STEP);
    assign c_pause = cmd_en && (cmd == CMD_PAUSE);

    assign mem_wen = prog_wen && (state_q == ST_IDLE);

    seq2_progmem #(.AW(AW), .IW(IW)) u_mem (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (mem_wen),
        .wr_addr (prog_addr),
        .wr_data (prog_data),
        .rd_en   (rd_en),
        .rd_addr (seq_next),
        .rd_data (seq_inst)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            step_q   <= 1'b0;
            chk_q    <= 1'b0;
            pend_q   <= 1'b0;
            icount_q <= '0;
            trap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            chk_q    <= chk_d;
            pend_q   <= pend_d;
            icount_q <= icount_d;
            trap_q   <= trap_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        chk_d    = chk_q;
        pend_d   = pend_q;
        icount_d = icount_q;
        trap_d   = trap_q;
        rd_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (c_run || c_step) begin
                    state_d  = ST_BOOT;
                    step_d   = c_step;
                    chk_d    = 1'b0;
                    pend_d   = 1'b0;
                    icount_d = '0;
                    trap_d   = 1'b0;
                end
            end
            ST_BOOT: begin
                state_d = c_stop ? ST_IDLE : ST_FETCH;
            end
            ST_FETCH: begin
                chk_d = 1'b0;
                if (c_stop) begin
                    state_d = ST_IDLE;
                end else if (chk_q && bp_en && (seq_next == bp_addr)) begin
                    // Breakpoint hit on the post-issue address: no read, no issue.
                    state_d = ST_PAUSED;
                    pend_d  = 1'b0;
                end else begin
                    rd_en   = 1'b1;
                    state_d = ST_ISSUE;
                    if (c_pause) begin
                        pend_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (icount_q != '1) begin
                    icount_d = icount_q + CNTW'(1);
                end
                if (op_illegal(seq_inst[IW-1 -: 4])) begin
                    trap_d = 1'b1;
                end
                if (c_stop) begin
                    state_d = ST_IDLE;
                end else if (op_illegal(seq_inst[IW-1 -: 4])) begin
                    state_d = ST_ERROR;
                end else if (step_q || pend_q || c_pause) begin
                    state_d = ST_PAUSED;
                    pend_d  = 1'b0;
                end else begin
                    state_d = ST_FETCH;
                    chk_d   = 1'b1;
                end
            end
            ST_PAUSED: begin
                if (c_stop) begin
                    state_d = ST_IDLE;
                end else if (c_run || c_step) begin
                    state_d = ST_FETCH;
                    step_d  = c_step;
                    chk_d   = 1'b0;
                end
            end
            ST_ERROR: begin
                if (c_stop) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign seq_inst_en = (state_q == ST_ISSUE);
    assign seq_reset   = (state_q == ST_IDLE);
    assign state       = state_q;
    assign icount      = icount_q;
    assign trap        = trap_q;

endmodule
